// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: operands are captured on start and added
// LSB-first through one full-adder slice and a registered carry. The visible
// sum/carry_out registers update only once the whole word has been processed.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_shifted;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             bit_sum;
    logic             bit_carry;
    logic             last_bit;
    logic             accept;

    // Full-adder slice on the current LSBs and the running carry.
    assign bit_sum   = a_sh[0] ^ b_sh[0] ^ c;
    assign bit_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    assign last_bit  = (cnt == CW'(WIDTH - 1));

    // A new operation may begin from IDLE or directly from DONE (back-to-back).
    assign accept = start && ((state == IDLE) || (state == DONE));

    // Result register fills from the MSB side; a 1-bit word has nothing to shift.
    generate
        if (WIDTH == 1) begin : g_one
            assign res_shifted = bit_sum;
        end else begin : g_multi
            assign res_shifted = {bit_sum, res[WIDTH-1:1]};
        end
    endgenerate

    // Status outputs are decoded purely from the state register.
    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, per-bit shifting and final result commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            c         <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            res  <= '0;
            c    <= 1'b0;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            c    <= bit_carry;
            res  <= res_shifted;
            cnt  <= cnt + CW'(1);
            if (last_bit) begin
                sum       <= res_shifted;
                carry_out <= bit_carry;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed operations on an 8-bit and a 1-bit instance.
// The driver queues expected results; a monitor pops them on each done pulse.
module tb_serial_adder;

    typedef struct {
        logic [7:0] s;
        logic       c;
        int         t;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start8, start1;
    logic [7:0] a8, b8, sum8;
    logic [0:0] a1, b1, sum1;
    logic       busy8, done8, cout8;
    logic       busy1, done1, cout1;

    int         cyc = 0;
    int         n_vec = 0;
    int         n_fail = 0;
    logic [7:0] last_sum = 8'h00;
    exp_t       q8[$];
    exp_t       q1[$];
    exp_t       e8, e1;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .carry_out(cout8)
    );

    serial_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .carry_out(cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: compare every done pulse against the head of the expectation queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (done8) begin
                if (q8.size() == 0) begin
                    check("u8 unexpected done", 32'd1, 32'd0);
                end else begin
                    e8 = q8.pop_front();
                    $display("u8 result: sum=0x%02h cout=%0d cycle=%0d (want 0x%02h/%0d @%0d)",
                             sum8, cout8, cyc, e8.s, e8.c, e8.t);
                    check("u8 sum", {24'd0, sum8}, {24'd0, e8.s});
                    check("u8 carry_out", {31'd0, cout8}, {31'd0, e8.c});
                    check("u8 done cycle", cyc, e8.t);
                end
            end
            if (done1) begin
                if (q1.size() == 0) begin
                    check("u1 unexpected done", 32'd1, 32'd0);
                end else begin
                    e1 = q1.pop_front();
                    $display("u1 result: sum=%0d cout=%0d cycle=%0d (want %0d/%0d @%0d)",
                             sum1, cout1, cyc, e1.s, e1.c, e1.t);
                    check("u1 sum", {31'd0, sum1}, {24'd0, e1.s});
                    check("u1 carry_out", {31'd0, cout1}, {31'd0, e1.c});
                    check("u1 done cycle", cyc, e1.t);
                end
            end
        end
    end

    // One 8-bit operation with busy-width, sum-hold and done-width checks.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] es, input logic ec);
        @(negedge clk);
        a8 = av; b8 = bv; start8 = 1'b1;
        q8.push_back('{s: es, c: ec, t: cyc + 9});
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            check("busy during shift", {31'd0, busy8}, 32'd1);
            check("sum held during shift", {24'd0, sum8}, {24'd0, last_sum});
            check("done low during shift", {31'd0, done8}, 32'd0);
        end
        @(negedge clk);
        check("busy low in done cycle", {31'd0, busy8}, 32'd0);
        @(negedge clk);
        check("done one cycle wide", {31'd0, done8}, 32'd0);
        last_sum = es;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
        a8 = '0; b8 = '0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy8}, 32'd0);
        check("reset done", {31'd0, done8}, 32'd0);
        check("reset sum", {24'd0, sum8}, 32'd0);
        check("reset carry_out", {31'd0, cout8}, 32'd0);
        #1 rst = 1'b0;

        // Plain additions.
        run_op(8'h00, 8'h00, 8'h00, 1'b0);
        run_op(8'h3C, 8'h05, 8'h41, 1'b0);
        run_op(8'hFF, 8'h01, 8'h00, 1'b1);
        run_op(8'h80, 8'h80, 8'h00, 1'b1);
        run_op(8'hAA, 8'h55, 8'hFF, 1'b0);

        // Start during SHIFT is ignored and operand changes after capture do nothing.
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
        q8.push_back('{s: 8'h30, c: 1'b0, t: cyc + 9});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom);
            start8 = 1'b0;
            if (i == 2) begin
                a8 = 8'h7F; b8 = 8'h7F; start8 = 1'b1;
            end
        end
        repeat (12) @(negedge clk);
        last_sum = 8'h30;

        // Asynchronous reset mid-operation.
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async reset busy", {31'd0, busy8}, 32'd0);
        check("async reset done", {31'd0, done8}, 32'd0);
        check("async reset sum", {24'd0, sum8}, 32'd0);
        check("async reset carry_out", {31'd0, cout8}, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        last_sum = 8'h00;
        run_op(8'h01, 8'h02, 8'h03, 1'b0);

        // Back-to-back with start held high, new operands in the done cycle.
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        q8.push_back('{s: 8'h02, c: 1'b0, t: cyc + 9});
        repeat (9) @(negedge clk);
        check("b2b first done present", {31'd0, done8}, 32'd1);
        a8 = 8'hF0; b8 = 8'h20;
        q8.push_back('{s: 8'h10, c: 1'b1, t: cyc + 9});
        @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(negedge clk);

        // WIDTH=1 instance: single op then back-to-back.
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0; start1 = 1'b1;
        q1.push_back('{s: 8'h01, c: 1'b0, t: cyc + 2});
        @(negedge clk);
        start1 = 1'b0;
        check("u1 busy", {31'd0, busy1}, 32'd1);
        repeat (3) @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; start1 = 1'b1;
        q1.push_back('{s: 8'h00, c: 1'b1, t: cyc + 2});
        @(negedge clk);
        check("u1 b2b busy", {31'd0, busy1}, 32'd1);
        @(negedge clk);
        q1.push_back('{s: 8'h00, c: 1'b1, t: cyc + 2});
        @(negedge clk);
        start1 = 1'b0;
        repeat (6) @(negedge clk);

        check("u8 results outstanding", q8.size(), 32'd0);
        check("u1 results outstanding", q1.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
